// File: rtl/pam_udiv_16by8_seq.sv
// pam_udiv_16by8_seq: sequential unsigned restoring divider, 16-bit dividend by 8-bit divisor.
// Resolves one quotient bit per clock, so a normal division takes 8 BUSY cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   z          16-bit dividend
//   y          8-bit divisor
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE only)
//   q          8-bit quotient (8'hFF when ovf)
//   r          8-bit remainder (8'hFF when ovf)
//   ovf        quotient does not fit in 8 bits, or divisor is 0
//   dbz        divisor was 0
//   out_valid  q, r, ovf, dbz valid (DONE only)
//   out_ready  consumer accepts result
//
// Build option: define PAM_UDIV_EARLY_EXIT_EN to send overflow operands straight from
// IDLE to DONE, skipping the 8 iteration cycles.
module pam_udiv_16by8_seq #(
    parameter int unsigned ITER_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] z,
    input  logic [7:0]  y,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        ovf,
    output logic        dbz,
    output logic        out_valid,
    input  logic        out_ready
);

    generate
        if (ITER_PER_CYCLE != 1) begin : g_bad_iter
            $error("pam_udiv_16by8_seq: only ITER_PER_CYCLE = 1 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  pr_q, pr_d;     // partial remainder; bit 8 stays 0 while pr < y
    logic [7:0]  dsr_q, dsr_d;   // low dividend byte, consumed MSB first
    logic [7:0]  quo_q, quo_d;
    logic [7:0]  y_q, y_d;
    logic        ovf_q, ovf_d;
    logic        dbz_q, dbz_d;

    logic [8:0]  trial;
    logic        qbit;
    logic        acc_ovf;
    logic        unused_pr_msb;

    assign unused_pr_msb = pr_q[8];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        trial   = {pr_q[7:0], dsr_q[7]};
        qbit    = (trial >= {1'b0, y_q});
        // If the high byte already reaches y, the quotient needs more than 8 bits.
        acc_ovf = (z[15:8] >= y);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    y_d   = y;
                    pr_d  = {1'b0, z[15:8]};
                    dsr_d = z[7:0];
                    cnt_d = 4'd0;
                    quo_d = 8'd0;
                    ovf_d = acc_ovf;
                    dbz_d = (y == 8'd0);
`ifdef PAM_UDIV_EARLY_EXIT_EN
                    if (acc_ovf) begin
                        state_d = StDone;
                        quo_d   = 8'hFF;
                        pr_d    = 9'h0FF;
                    end else begin
                        state_d = StBusy;
                    end
`else
                    state_d = StBusy;
`endif
                end
            end
            StBusy: begin
                pr_d  = qbit ? (trial - {1'b0, y_q}) : trial;
                quo_d = {quo_q[6:0], qbit};
                dsr_d = {dsr_q[6:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    state_d = StDone;
                    // Iteration result is meaningless on overflow; report saturated values.
                    if (ovf_q) begin
                        quo_d = 8'hFF;
                        pr_d  = 9'h0FF;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            pr_q    <= 9'd0;
            dsr_q   <= 8'd0;
            quo_q   <= 8'd0;
            y_q     <= 8'd0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign q         = quo_q;
    assign r         = pr_q[7:0];
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_pam_udiv_16by8_seq.sv
// Self-checking bench for pam_udiv_16by8_seq. Expected results come from plain integer
// division in ref_div, not from any model of the iteration.
module tb_pam_udiv_16by8_seq;

    logic        clk;
    logic        rst;
    logic [15:0] z;
    logic [7:0]  y;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dbz;
    logic        out_valid;
    logic        out_ready;

    int checks;
    int failures;

    pam_udiv_16by8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .z         (z),
        .y         (y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .r         (r),
        .ovf       (ovf),
        .dbz       (dbz),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: overflow when the true quotient exceeds 255 or y is zero.
    task automatic ref_div(input logic [15:0] zi, input logic [7:0] yi,
                           output logic [7:0] eq, output logic [7:0] er,
                           output logic eovf, output logic edbz, output int elat);
        int unsigned quot;
        edbz = (yi == 8'd0);
        if (yi == 8'd0) quot = 256;
        else            quot = int'(zi) / int'(yi);
        eovf = (quot > 255);
        if (eovf) begin
            eq = 8'hFF;
            er = 8'hFF;
        end else begin
            eq = 8'(quot);
            er = 8'(int'(zi) % int'(yi));
        end
`ifdef PAM_UDIV_EARLY_EXIT_EN
        elat = eovf ? 1 : 9;
`else
        elat = 9;
`endif
    endtask

    // Offers one operand pair, waits for the result; lat counts edges from acceptance
    // (inclusive) until out_valid is seen. Optionally consumes the result.
    task automatic run_op(input logic [15:0] zi, input logic [7:0] yi, input bit consume,
                          output logic [7:0] qo, output logic [7:0] ro,
                          output logic ovfo, output logic dbzo, output int lat,
                          output bit tmo);
        int w;
        tmo = 1'b0;
        lat = 0;
        qo = 8'd0; ro = 8'd0; ovfo = 1'b0; dbzo = 1'b0;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            tmo = 1'b1;
            return;
        end
        z = zi;
        y = yi;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        z = 16'($urandom);
        y = 8'($urandom);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            tmo = 1'b1;
            return;
        end
        qo = q; ro = r; ovfo = ovf; dbzo = dbz;
        if (consume) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        z = 16'd0;
        y = 8'd0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        checks++;
        if (q !== 8'd0 || r !== 8'd0 || ovf !== 1'b0 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: q=%0d r=%0d ovf=%b dbz=%b required 0 0 0 0", q, r, ovf, dbz);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Directed vector: compares all outputs and latency against the reference.
    task automatic test_vector(input string name, input logic [15:0] zi, input logic [7:0] yi);
        logic [7:0] gq, gr, eq, er;
        logic       govf, gdbz, eovf, edbz;
        int         glat, elat;
        bit         tmo;
        ref_div(zi, yi, eq, er, eovf, edbz, elat);
        run_op(zi, yi, 1'b1, gq, gr, govf, gdbz, glat, tmo);
        checks++;
        if (tmo) begin
            failures++;
            $display("FAIL %s_timeout: no result, required one", name);
            return;
        end
        checks++;
        if (gq !== eq || gr !== er) begin
            failures++;
            $display("FAIL %s_qr: q=%0d r=%0d required q=%0d r=%0d", name, gq, gr, eq, er);
        end
        checks++;
        if (govf !== eovf || gdbz !== edbz) begin
            failures++;
            $display("FAIL %s_flags: ovf=%b dbz=%b required ovf=%b dbz=%b",
                     name, govf, gdbz, eovf, edbz);
        end
        checks++;
        if (glat != elat) begin
            failures++;
            $display("FAIL %s_latency: %0d edges required %0d", name, glat, elat);
        end
    endtask

    task automatic test_normal;
        test_vector("div_1000_7", 16'd1000, 8'd7);
        test_vector("div_32767_200", 16'd32767, 8'd200);
        test_vector("div_255_16", 16'd255, 8'd16);
    endtask

    task automatic test_overflow;
        test_vector("ovf_fffe_ff", 16'hFFFE, 8'hFF);
        test_vector("dbz_12345", 16'd12345, 8'd0);
        test_vector("ovf_edge", 16'h0700, 8'd7);
    endtask

    task automatic test_backpressure;
        logic [7:0] gq, gr;
        logic       govf, gdbz;
        int         glat;
        bit         tmo;
        run_op(16'd1000, 8'd7, 1'b0, gq, gr, govf, gdbz, glat, tmo);
        checks++;
        if (tmo) begin
            failures++;
            $display("FAIL bp_timeout: no result, required one");
            return;
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                z = 16'd500;
                y = 8'd3;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (q !== 8'd142 || r !== 8'd6 || ovf !== 1'b0 || dbz !== 1'b0 || in_ready !== 1'b0
                || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold%0d: q=%0d r=%0d ovf=%b dbz=%b ir=%b ov=%b required 142 6 0 0 0 1",
                         i, q, r, ovf, dbz, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        // A captured pulse would have left the block busy with 500/3.
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_nocapture: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        z = 16'd40000;
        y = 8'd250;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midop_reset: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL midop_noresult: out_valid=%b required 0", out_valid);
            end
        end
        test_vector("after_reset_255_16", 16'd255, 8'd16);
    endtask

    task automatic test_random;
        logic [7:0]  gq, gr, eq, er, yi;
        logic [15:0] zi;
        logic        govf, gdbz, eovf, edbz;
        int          glat, elat;
        bit          tmo;
        for (int n = 0; n < 3000; n++) begin
            if (n % 10 == 9) begin
                zi = 16'($urandom);
                yi = 8'($urandom);
            end else begin
                yi = 8'($urandom_range(1, 255));
                zi = {8'($urandom_range(0, int'(yi) - 1)), 8'($urandom)};
            end
            ref_div(zi, yi, eq, er, eovf, edbz, elat);
            run_op(zi, yi, 1'b1, gq, gr, govf, gdbz, glat, tmo);
            checks++;
            if (tmo || gq !== eq || gr !== er || govf !== eovf || gdbz !== edbz || glat != elat) begin
                failures++;
                $display("FAIL rand%0d z=%0d y=%0d: q=%0d r=%0d ovf=%b dbz=%b lat=%0d tmo=%b required q=%0d r=%0d ovf=%b dbz=%b lat=%0d",
                         n, zi, yi, gq, gr, govf, gdbz, glat, tmo, eq, er, eovf, edbz, elat);
            end
            if (!eovf && !tmo) begin
                checks++;
                if ((int'(gq) * int'(yi) + int'(gr)) != int'(zi) || gr >= yi) begin
                    failures++;
                    $display("FAIL rand_identity%0d: q*y+r=%0d r=%0d required %0d and r<%0d",
                             n, int'(gq) * int'(yi) + int'(gr), gr, zi, yi);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_normal();
        test_overflow();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
